// File: rtl/instr_fetch_queue.sv
// Circular instruction queue between fetch and decode.
// Fetch packets are compacted by mask on write; decode sees the oldest
// DECODE_NUM entries, combinationally derived from registered state only.
module instr_fetch_queue #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned FETCH_NUM  = 4,
  parameter int unsigned DECODE_NUM = 4,
  parameter int unsigned ADDR_WIDTH = 64
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   flush,
  input  logic                                   fetch_valid,
  output logic                                   fetch_ready,
  input  logic [FETCH_NUM-1:0][31:0]             fetch_instr,
  input  logic [ADDR_WIDTH-1:0]                  fetch_pc,
  input  logic [FETCH_NUM-1:0]                   fetch_mask,
  output logic [DECODE_NUM-1:0][31:0]            dec_instr,
  output logic [DECODE_NUM-1:0][ADDR_WIDTH-1:0]  dec_pc,
  output logic [DECODE_NUM-1:0]                  dec_valid,
  input  logic                                   dec_ready,
  output logic [$clog2(DEPTH):0]                 count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [31:0]           ent_instr [DEPTH];
  logic [ADDR_WIDTH-1:0] ent_pc    [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  logic             enq;
  logic             deq;
  logic [CNT_W-1:0] n_in;
  logic [CNT_W-1:0] n_in_eff;
  logic [CNT_W-1:0] n_avail;
  logic [CNT_W-1:0] n_out;
  logic [PTR_W-1:0] wr_idx [FETCH_NUM];
  logic             wr_en  [FETCH_NUM];
  logic [PTR_W-1:0] rd_idx [DECODE_NUM];

  // Ready depends on current occupancy only, so same-cycle dequeue never matters
  assign fetch_ready = (count <= CNT_W'(DEPTH - FETCH_NUM));

  // Mask compaction: each set slot lands at tail + (number of set slots below it)
  always_comb begin
    n_in = '0;
    enq  = fetch_valid & fetch_ready & ~flush;
    for (int k = 0; k < int'(FETCH_NUM); k++) begin
      wr_idx[k] = tail + n_in[PTR_W-1:0];
      wr_en[k]  = enq & fetch_mask[k];
      if (fetch_mask[k]) n_in = n_in + CNT_W'(1);
    end
    n_in_eff = enq ? n_in : '0;
  end

  // Dequeue sizing: decode takes every valid slot when ready
  always_comb begin
    n_avail = (count < CNT_W'(DECODE_NUM)) ? count : CNT_W'(DECODE_NUM);
    deq     = dec_ready & ~flush;
    n_out   = deq ? n_avail : '0;
  end

  // Decode window: oldest entries, invalid slots forced to zero
  always_comb begin
    for (int j = 0; j < int'(DECODE_NUM); j++) begin
      rd_idx[j]    = head + PTR_W'(j);
      dec_valid[j] = (CNT_W'(j) < n_avail);
      dec_instr[j] = dec_valid[j] ? ent_instr[rd_idx[j]] : '0;
      dec_pc[j]    = dec_valid[j] ? ent_pc[rd_idx[j]]    : '0;
    end
  end

  // Entry storage; contents are not reset, occupancy alone defines validity
  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(FETCH_NUM); k++) begin
      if (wr_en[k]) begin
        ent_instr[wr_idx[k]] <= fetch_instr[k];
        ent_pc[wr_idx[k]]    <= fetch_pc + (ADDR_WIDTH'(k) << 2);
      end
    end
  end

  // Pointers and occupancy; flush empties the queue and wins over enq/deq
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + n_out[PTR_W-1:0];
      tail  <= tail + n_in_eff[PTR_W-1:0];
      count <= count + n_in_eff - n_out;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed testbench for instr_fetch_queue with immediate-assertion checks.
module tb_instr_fetch_queue;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              fetch_valid;
  logic              fetch_ready;
  logic [3:0][31:0]  fetch_instr;
  logic [63:0]       fetch_pc;
  logic [3:0]        fetch_mask;
  logic [3:0][31:0]  dec_instr;
  logic [3:0][63:0]  dec_pc;
  logic [3:0]        dec_valid;
  logic              dec_ready;
  logic [4:0]        count;

  int errors = 0;
  int checks = 0;
  logic [63:0] mq [$];

  instr_fetch_queue #(.DEPTH(16), .FETCH_NUM(4), .DECODE_NUM(4), .ADDR_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_instr(fetch_instr), .fetch_pc(fetch_pc), .fetch_mask(fetch_mask),
    .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_valid(dec_valid),
    .dec_ready(dec_ready), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word derived from its PC so order can be checked from PC alone
  function automatic logic [31:0] instr_of(input logic [63:0] pc);
    return {16'hBEEF, pc[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full or sparse packet whose instructions follow instr_of(pc + 4k)
  task automatic set_pkt(input logic [63:0] pc, input logic [3:0] mask);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    fetch_mask  = mask;
    for (int k = 0; k < 4; k++) fetch_instr[k] = instr_of(pc + 64'(4 * k));
  endtask

  initial begin
    logic [63:0] next_pc;
    logic [63:0] e;
    int pkts;

    rst_n = 1'b0; flush = 1'b0; fetch_valid = 1'b0; dec_ready = 1'b0;
    fetch_instr = '0; fetch_pc = '0; fetch_mask = '0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(fetch_ready), 64'd1);
    chk("rst_valid", 64'(dec_valid), 64'd0);
    #10 rst_n = 1'b1;
    tick(); tick();

    // Single full packet
    fetch_valid = 1'b1; fetch_pc = 64'h1000; fetch_mask = 4'b1111;
    fetch_instr[0] = 32'hAAAA_0000; fetch_instr[1] = 32'hBBBB_0000;
    fetch_instr[2] = 32'hCCCC_0000; fetch_instr[3] = 32'hDDDD_0000;
    chk("no_bypass_valid", 64'(dec_valid), 64'd0);
    tick();
    fetch_valid = 1'b0;
    chk("single_valid", 64'(dec_valid), 64'hF);
    chk("single_count", 64'(count), 64'd4);
    chk("single_pc0", dec_pc[0], 64'h1000);
    chk("single_pc1", dec_pc[1], 64'h1004);
    chk("single_pc2", dec_pc[2], 64'h1008);
    chk("single_pc3", dec_pc[3], 64'h100C);
    chk("single_i0", 64'(dec_instr[0]), 64'hAAAA_0000);
    chk("single_i3", 64'(dec_instr[3]), 64'hDDDD_0000);
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    chk("single_drain_count", 64'(count), 64'd0);
    chk("single_drain_valid", 64'(dec_valid), 64'd0);

    // Sparse mask 1010: slots 1 and 3 only
    set_pkt(64'h2000, 4'b1010);
    tick();
    fetch_valid = 1'b0;
    chk("sparse_valid", 64'(dec_valid), 64'h3);
    chk("sparse_count", 64'(count), 64'd2);
    chk("sparse_i0", 64'(dec_instr[0]), 64'(instr_of(64'h2004)));
    chk("sparse_pc0", dec_pc[0], 64'h2004);
    chk("sparse_i1", 64'(dec_instr[1]), 64'(instr_of(64'h200C)));
    chk("sparse_pc1", dec_pc[1], 64'h200C);
    chk("sparse_i2_zero", 64'(dec_instr[2]), 64'd0);
    chk("sparse_pc2_zero", dec_pc[2], 64'd0);
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    chk("sparse_drain", 64'(count), 64'd0);

    // Fill (head starts at 6, so storage wraps) until ready drops
    next_pc = 64'h8000;
    pkts = 0;
    while (fetch_ready && pkts < 8) begin
      chk("fill_ready", 64'(fetch_ready), 64'(count <= 5'd12));
      set_pkt(next_pc, 4'b1111);
      for (int k = 0; k < 4; k++) mq.push_back(next_pc + 64'(4 * k));
      next_pc += 64'h10;
      pkts++;
      tick();
    end
    fetch_valid = 1'b0;
    chk("fill_pkts", 64'(pkts), 64'd4);
    chk("full_count", 64'(count), 64'd16);
    chk("full_ready", 64'(fetch_ready), 64'd0);

    // Streaming: continuous fetch and decode for 20 cycles
    for (int c = 0; c < 20; c++) begin
      chk("stream_cnt_range", 64'(count >= 5'd12 && count <= 5'd16), 64'd1);
      chk("stream_valid", 64'(dec_valid), 64'hF);
      for (int j = 0; j < 4; j++) begin
        e = mq.pop_front();
        chk("stream_pc", dec_pc[j], e);
        chk("stream_instr", 64'(dec_instr[j]), 64'(instr_of(e)));
      end
      set_pkt(next_pc, 4'b1111);
      dec_ready = 1'b1;
      if (fetch_ready) begin
        for (int k = 0; k < 4; k++) mq.push_back(next_pc + 64'(4 * k));
        next_pc += 64'h10;
      end
      tick();
    end
    fetch_valid = 1'b0; dec_ready = 1'b0;
    chk("stream_model_count", 64'(count), 64'(mq.size()));

    // Asynchronous reset mid-cycle while occupied
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_ready", 64'(fetch_ready), 64'd1);
    chk("async_rst_valid", 64'(dec_valid), 64'd0);
    chk("async_rst_pc0", dec_pc[0], 64'd0);
    #2 rst_n = 1'b1;
    tick();

    // Build count = 6, then enqueue 3 while dequeuing 4
    set_pkt(64'h3000, 4'b1111);
    tick();
    set_pkt(64'h3010, 4'b0011);
    tick();
    chk("simul_pre_count", 64'(count), 64'd6);
    chk("simul_pre_pc0", dec_pc[0], 64'h3000);
    set_pkt(64'h4000, 4'b0111);
    dec_ready = 1'b1;
    tick();
    fetch_valid = 1'b0;
    chk("simul_count", 64'(count), 64'd5);
    chk("simul_valid", 64'(dec_valid), 64'hF);
    chk("simul_pc0", dec_pc[0], 64'h3010);
    chk("simul_pc1", dec_pc[1], 64'h3014);
    chk("simul_pc2", dec_pc[2], 64'h4000);
    chk("simul_pc3", dec_pc[3], 64'h4004);
    tick();
    dec_ready = 1'b0;
    chk("simul_tail_count", 64'(count), 64'd1);
    chk("simul_tail_valid", 64'(dec_valid), 64'h1);
    chk("simul_tail_pc", dec_pc[0], 64'h4008);

    // Bring count to 9, then flush with concurrent fetch and decode
    set_pkt(64'h5000, 4'b1111);
    tick();
    set_pkt(64'h5010, 4'b1111);
    tick();
    chk("flush_pre_count", 64'(count), 64'd9);
    set_pkt(64'h6000, 4'b1111);
    flush = 1'b1; dec_ready = 1'b1;
    tick();
    flush = 1'b0; fetch_valid = 1'b0; dec_ready = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(dec_valid), 64'd0);
    chk("flush_ready", 64'(fetch_ready), 64'd1);
    set_pkt(64'h7000, 4'b0001);
    tick();
    chk("post_flush_count", 64'(count), 64'd1);
    chk("post_flush_valid", 64'(dec_valid), 64'h1);
    chk("post_flush_pc", dec_pc[0], 64'h7000);

    // Empty mask is a no-op
    set_pkt(64'h9000, 4'b0000);
    tick();
    fetch_valid = 1'b0;
    chk("nomask_count", 64'(count), 64'd1);
    chk("nomask_pc", dec_pc[0], 64'h7000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
